if_fetch_ctrl: RTL and testbench

//  Instruction-fetch front end driving the IF/ID pipeline register: owns the PC,

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_fetch_ctrl_pc_next_gen.sv | 14 +
 rtl/if_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_if_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, the NOP encoding and the IF/ID select codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_RESP  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] SEL_PASS  = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b01;
  localparam logic [1:0] SEL_FLUSH = 2'b10;

endpackage

// File: rtl/if_fetch_ctrl_pc_next_gen.sv
// Next fetch PC: sequential +4 or a word-aligned redirect target.
module pc_next_gen (
  input  logic [31:0] fetch_pc,
  input  logic        redirect,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc
);

  logic [31:0] target_aligned;

  assign target_aligned = branch_target & ~32'h0000_0003;
  assign next_pc        = redirect ? target_aligned : (fetch_pc + 32'd4);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: owns the PC, runs one AR/R read at a time and
// feeds {pc, instr, instr_sel, bus_stall} to the IF/ID register.
module if_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_ext,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [1:0]  instr_sel,
  output logic [1:0]  bus_stall,
  output logic        fetch_err
);

  fetch_state_e state, state_nxt;
  logic [31:0]  fetch_pc;
  logic [31:0]  next_pc;
  logic         pc_load;
  logic         capture;
  logic         fetch_stall;

  pc_next_gen u_pc_next_gen (
    .fetch_pc      (fetch_pc),
    .redirect      (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      pc        <= 32'h0000_0000;
      instr     <= NOP;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pc_load) fetch_pc <= next_pc;
      if (capture) begin
        instr     <= (rresp != 2'b00) ? NOP : rdata;
        pc        <= fetch_pc;
        fetch_err <= fetch_err | (rresp != 2'b00);
      end
    end
  end

  // A taken branch in S_VALID redirects even under load_use; load_use alone holds.
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    pc_load   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_REQ: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_RESP;
      end
      S_RESP: begin
        rready = 1'b1;
        if (rvalid) begin
          capture   = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall_ext && (branch_taken || !load_use)) begin
          pc_load   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  assign araddr      = fetch_pc;
  assign fetch_stall = (state != S_VALID);
  assign bus_stall   = {stall_ext, fetch_stall};

  always_comb begin
    instr_sel = SEL_PASS;
    if (branch_taken)  instr_sel = SEL_FLUSH;
    else if (load_use) instr_sel = SEL_HOLD;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: instruction-memory responder plus a scoreboard of
// accepted reads compared against each instruction presented to IF/ID.
module tb_if_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_ext = 1'b0;
  logic        load_use = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [1:0]  instr_sel;
  logic [1:0]  bus_stall;
  logic        fetch_err;

  logic        rvalid_en = 1'b1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] last_ar = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb[$];

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .stall_ext(stall_ext), .load_use(load_use),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .pc(pc), .instr(instr), .instr_sel(instr_sel), .bus_stall(bus_stall),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return err_en && (a == err_addr);
  endfunction

  assign rdata  = mem_word(last_ar);
  assign rresp  = is_err(last_ar) ? 2'b10 : 2'b00;
  assign rvalid = rvalid_en;

  // Every accepted AR pushes the instruction IF/ID should eventually see.
  always @(posedge clk) begin
    if (!rst && arvalid && arready) begin
      sb.push_back({araddr, is_err(araddr) ? 32'h0000_0013 : mem_word(araddr)});
      last_ar <= araddr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      cycles++;
      if (bus_stall[0] == 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL reset_arvalid got=%0b exp=1", arvalid); end
    n_tests++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr got=%h exp=00000000", araddr); end
    n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got=%0b exp=0", rready); end
    n_tests++; if (bus_stall !== 2'b01) begin n_fail++; $display("FAIL reset_bus_stall got=%b exp=01", bus_stall); end
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
    n_tests++; if (instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err got=%0b exp=0", fetch_err); end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_sequential();
    int cyc;
    bit to;
    logic [63:0] e;
    for (int k = 0; k < 3; k++) begin
      wait_valid(cyc, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL seq_timeout got=timeout exp=valid k=%0d", k); end
      if (k > 0) begin
        n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL seq_latency got=%0d exp=3", cyc); end
      end
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL seq_sb_empty got=0 exp=1 entries"); end
      else begin
        e = sb.pop_front();
        if (e[63:32] !== 32'(k * 4) || pc !== e[63:32] || instr !== e[31:0]) begin
          n_fail++;
          $display("FAIL seq_fetch got addr=%h pc=%h instr=%h exp addr=%h pc=%h instr=%h",
                   e[63:32], pc, instr, 32'(k * 4), e[63:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic redirect_to(input logic [31:0] tgt, input string name);
    int cyc;
    bit to;
    logic [63:0] e;
    branch_taken  = 1'b1;
    branch_target = tgt;
    #1;
    n_tests++; if (instr_sel !== SEL_FLUSH) begin n_fail++; $display("FAIL %s_sel got=%b exp=10", name, instr_sel); end
    step();
    branch_taken = 1'b0;
    n_tests++;
    if (arvalid !== 1'b1 || araddr !== (tgt & ~32'h3)) begin
      n_fail++; $display("FAIL %s_araddr got=%h/%0b exp=%h/1", name, araddr, arvalid, tgt & ~32'h3);
    end
    wait_valid(cyc, to);
    n_tests++;
    if (to || sb.size() == 0) begin n_fail++; $display("FAIL %s_timeout got=none exp=fetch", name); end
    else begin
      e = sb.pop_front();
      if (pc !== (tgt & ~32'h3) || instr !== e[31:0]) begin
        n_fail++; $display("FAIL %s_fetch got pc=%h instr=%h exp pc=%h instr=%h", name, pc, instr, tgt & ~32'h3, e[31:0]);
      end
    end
  endtask

  task automatic test_branch();
    redirect_to(32'h0000_0100, "branch");
    redirect_to(32'h0000_0203, "unaligned");
  endtask

  task automatic test_load_use();
    int cyc;
    bit to;
    logic [63:0] e;
    logic [31:0] held;
    redirect_to(32'h0000_0008, "to8");
    held = instr;
    load_use = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (instr_sel !== SEL_HOLD) begin n_fail++; $display("FAIL lu_sel got=%b exp=01", instr_sel); end
      step();
      n_tests++;
      if (arvalid !== 1'b0 || pc !== 32'h8 || instr !== held || bus_stall !== 2'b00) begin
        n_fail++; $display("FAIL lu_hold got arvalid=%0b pc=%h instr=%h bs=%b exp 0/00000008/%h/00",
                           arvalid, pc, instr, bus_stall, held);
      end
    end
    load_use = 1'b0;
    step();
    n_tests++; if (arvalid !== 1'b1 || araddr !== 32'hC) begin n_fail++; $display("FAIL lu_next got=%h/%0b exp=0000000c/1", araddr, arvalid); end
    wait_valid(cyc, to);
    if (!to && sb.size() != 0) e = sb.pop_front();
    n_tests++; if (to || pc !== 32'hC) begin n_fail++; $display("FAIL lu_fetch got pc=%h exp=0000000c", pc); end
    load_use = 1'b1;
    redirect_to(32'h0000_0040, "lu_branch");
    load_use = 1'b0;
  endtask

  task automatic test_stall();
    int cyc;
    bit to;
    logic [63:0] e;
    logic [31:0] pc0, in0;
    pc0 = pc;
    in0 = instr;
    stall_ext = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (bus_stall !== 2'b10) begin n_fail++; $display("FAIL stall_bs got=%b exp=10", bus_stall); end
      step();
      n_tests++;
      if (arvalid !== 1'b0 || pc !== pc0 || instr !== in0) begin
        n_fail++; $display("FAIL stall_frozen got arvalid=%0b pc=%h instr=%h exp 0/%h/%h", arvalid, pc, instr, pc0, in0);
      end
    end
    stall_ext = 1'b0;
    step();
    n_tests++; if (arvalid !== 1'b1 || araddr !== pc0 + 32'd4) begin n_fail++; $display("FAIL stall_resume got=%h exp=%h", araddr, pc0 + 32'd4); end
    stall_ext = 1'b1;
    #1;
    n_tests++; if (bus_stall !== 2'b11) begin n_fail++; $display("FAIL stall_inflight_bs got=%b exp=11", bus_stall); end
    wait_valid(cyc, to);
    if (!to && sb.size() != 0) e = sb.pop_front();
    n_tests++;
    if (to || pc !== pc0 + 32'd4 || instr !== mem_word(pc0 + 32'd4) || bus_stall !== 2'b10) begin
      n_fail++; $display("FAIL stall_inflight got pc=%h instr=%h bs=%b exp %h/%h/10", pc, instr, bus_stall, pc0 + 32'd4, mem_word(pc0 + 32'd4));
    end
    stall_ext = 1'b0;
  endtask

  task automatic test_bus_error();
    int cyc;
    bit to;
    logic [63:0] e;
    err_en   = 1'b1;
    err_addr = 32'h0000_0004;
    redirect_to(32'h0000_0004, "err");
    n_tests++; if (instr !== 32'h13) begin n_fail++; $display("FAIL err_instr got=%h exp=00000013", instr); end
    n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL err_flag got=%0b exp=1", fetch_err); end
    wait_valid(cyc, to);
    if (!to && sb.size() != 0) e = sb.pop_front();
    n_tests++;
    if (to || pc !== 32'h8 || instr !== mem_word(32'h8) || fetch_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got pc=%h instr=%h err=%0b exp 00000008/%h/1", pc, instr, fetch_err, mem_word(32'h8));
    end
    err_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    logic [63:0] e;
    rvalid_en = 1'b0;
    step();
    step();
    n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL mid_in_resp got rready=%0b exp=1", rready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rvalid_en = 1'b1;
    arready = 1'b0;
    sb.delete();
    #1;
    n_tests++;
    if (araddr !== 32'h0 || bus_stall !== 2'b01 || arvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got araddr=%h bs=%b arvalid=%0b exp 00000000/01/1", araddr, bus_stall, arvalid);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (rready !== 1'b0 || bus_stall !== 2'b01 || instr !== 32'h13 || pc !== 32'h0) begin
        n_fail++; $display("FAIL mid_late_rvalid got rready=%0b bs=%b instr=%h pc=%h exp 0/01/00000013/00000000",
                           rready, bus_stall, instr, pc);
      end
    end
    arready = 1'b1;
    wait_valid(cyc, to);
    n_tests++;
    if (to || sb.size() == 0) begin n_fail++; $display("FAIL mid_refetch got=none exp=fetch"); end
    else begin
      e = sb.pop_front();
      if (pc !== 32'h0 || instr !== mem_word(32'h0) || e[63:32] !== 32'h0) begin
        n_fail++; $display("FAIL mid_refetch got pc=%h instr=%h exp 00000000/%h", pc, instr, mem_word(32'h0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_load_use();
    test_stall();
    test_bus_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
